// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: sequences wait/dark/play/gloat phases on slow ticks,
// arbitrates the first press and reports winner, false start and round count.
module tow_match_ctrl #(
    parameter int unsigned N_PLAYERS      = 2,
    parameter int unsigned WAIT_TICKS     = 2,
    parameter int unsigned GLOAT_TICKS    = 2,
    parameter int unsigned DARK_MIN_TICKS = 1,
    parameter int unsigned DARK_MAX_TICKS = 8,
    parameter int unsigned MAX_ROUNDS     = 15,
    parameter int unsigned FS_MODE        = 0,
    localparam int unsigned ID_W  = ($clog2(N_PLAYERS) > 1) ? $clog2(N_PLAYERS) : 1,
    localparam int unsigned RND_W = ($clog2(MAX_ROUNDS + 1) > 1) ? $clog2(MAX_ROUNDS + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 slowen,
    input  logic                 rand_bit,
    input  logic                 ready,
    input  logic [N_PLAYERS-1:0] press,
    input  logic                 endrnd,
    output logic                 leds_on,
    output logic                 clear,
    output logic [1:0]           leds_ctrl,
    output logic                 show_ready,
    output logic                 ready_clr,
    output logic                 clear_score,
    output logic                 winrnd,
    output logic                 false_start,
    output logic [ID_W-1:0]      win_id,
    output logic [RND_W-1:0]     round_cnt
);

    localparam int unsigned TICK_MAX_A = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
    localparam int unsigned TICK_MAX   = (TICK_MAX_A > DARK_MAX_TICKS) ? TICK_MAX_A : DARK_MAX_TICKS;
    localparam int unsigned TICK_W     = $clog2(TICK_MAX + 1);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_WAIT       = 3'd1,
        S_DARK       = 3'd2,
        S_PLAY       = 3'd3,
        S_GLOAT      = 3'd4,
        S_WAIT_READY = 3'd5
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_nxt;
    logic                fs_latched;
    logic                round_over;
    logic                press_any;
    logic [ID_W-1:0]     press_id;

    // Lowest-index set bit wins a simultaneous press.
    function automatic logic [ID_W-1:0] lowest_id(input logic [N_PLAYERS-1:0] p);
        lowest_id = '0;
        for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
            if (p[i]) lowest_id = ID_W'(i);
        end
    endfunction

    assign tick_nxt   = tick_cnt + TICK_W'(1);
    assign press_any  = |press;
    assign press_id   = lowest_id(press);
    assign round_over = endrnd || ((MAX_ROUNDS != 0) && (round_cnt >= RND_W'(MAX_ROUNDS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            tick_cnt    <= '0;
            winrnd      <= 1'b0;
            false_start <= 1'b0;
            fs_latched  <= 1'b0;
            win_id      <= '0;
            round_cnt   <= '0;
        end else begin
            winrnd      <= 1'b0;
            false_start <= 1'b0;
            case (state)
                S_RESET: begin
                    state     <= S_WAIT;
                    tick_cnt  <= '0;
                    round_cnt <= '0;
                end
                S_WAIT: begin
                    if (slowen) begin
                        if (tick_nxt == TICK_W'(WAIT_TICKS)) begin
                            state    <= S_DARK;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_nxt;
                        end
                    end
                end
                S_DARK, S_PLAY: begin
                    // A press outranks a coincident tick; in DARK it is a false start.
                    if (press_any) begin
                        state       <= S_GLOAT;
                        tick_cnt    <= '0;
                        win_id      <= press_id;
                        winrnd      <= 1'b1;
                        false_start <= (state == S_DARK);
                        fs_latched  <= (state == S_DARK);
                        if (round_cnt != '1) round_cnt <= round_cnt + RND_W'(1);
                    end else if (slowen) begin
                        if (state == S_DARK &&
                            ((rand_bit && tick_nxt >= TICK_W'(DARK_MIN_TICKS)) ||
                             tick_nxt == TICK_W'(DARK_MAX_TICKS))) begin
                            state    <= S_PLAY;
                            tick_cnt <= '0;
                        end else if (tick_cnt != '1) begin
                            tick_cnt <= tick_nxt;
                        end
                    end
                end
                S_GLOAT: begin
                    if (slowen) begin
                        if (tick_nxt == TICK_W'(GLOAT_TICKS)) begin
                            state      <= round_over ? S_WAIT_READY : S_DARK;
                            tick_cnt   <= '0;
                            fs_latched <= 1'b0;
                        end else begin
                            tick_cnt <= tick_nxt;
                        end
                    end
                end
                S_WAIT_READY: begin
                    if (slowen && ready) begin
                        state     <= S_WAIT;
                        tick_cnt  <= '0;
                        round_cnt <= '0;
                    end else if (slowen && tick_cnt != '1) begin
                        tick_cnt <= tick_nxt;
                    end
                end
                default: begin
                    state    <= S_RESET;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // Phase-level outputs decoded straight from the state register.
    always_comb begin
        leds_on     = 1'b0;
        clear       = 1'b1;
        leds_ctrl   = 2'd0;
        show_ready  = 1'b0;
        ready_clr   = 1'b1;
        clear_score = 1'b0;
        case (state)
            S_WAIT: begin
                clear_score = 1'b1;
            end
            S_DARK: begin
                clear     = 1'b0;
                leds_ctrl = 2'd1;
            end
            S_PLAY: begin
                clear     = 1'b0;
                leds_on   = 1'b1;
                leds_ctrl = 2'd3;
            end
            S_GLOAT: begin
                leds_ctrl = (fs_latched && FS_MODE != 0) ? 2'd2 : 2'd3;
            end
            S_WAIT_READY: begin
                leds_ctrl  = 2'd3;
                show_ready = 1'b1;
                ready_clr  = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule
